dhcp_reply_parser: RTL and testbench

- Receive-side companion to the DHCP DISCOVER builder in the ColorLight_i5 network-parameter block.
- Consumes the UDP payload of an incoming DHCP reply (OFFER or ACK) as a byte-wide AXIS stream.
- Checks the reply against the outstanding transaction (xid, MAC, magic cookie) and extracts offered IP, server id, router and subnet mask.
- Exposes accepted fields plus a start/finished handshake to the network-parameter controller.

---
 rtl/dhcp_reply_parser.sv | 214 +++++++++++++++++++++
 tb/tb_dhcp_reply_parser.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dhcp_reply_parser.sv
// Parses the UDP payload of a DHCP OFFER/ACK, validates it against the pending transaction
// and publishes the negotiated addresses. Define DHCP_LEASE_EN to also capture option 51.
module dhcp_reply_parser #(
    parameter int MAX_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        finished,
    output logic        accepted,
    input  logic [31:0] xid,
    input  logic [47:0] local_mac,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic [7:0]  msg_type,
    output logic [31:0] offered_ip,
    output logic [31:0] server_id,
    output logic [31:0] router_ip,
    output logic [31:0] subnet_mask
`ifdef DHCP_LEASE_EN
    ,output logic [31:0] lease_time
`endif
);
    localparam logic [31:0] MAGIC = 32'h6382_5363;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_OPT_CODE, S_OPT_LEN, S_OPT_DATA, S_DRAIN, S_DONE
    } state_t;

    state_t      r_state, w_state_next;
    logic [10:0] r_cnt;
    logic [7:0]  r_code, r_len, r_idx;
    logic        r_err, r_seen53, r_fin, r_acc;
    logic [31:0] r_xid;
    logic [47:0] r_mac;
    logic [7:0]  r_sh_msg, r_msg;
    logic [31:0] r_sh_ip, r_sh_sid, r_sh_rtr, r_sh_mask;
    logic [31:0] r_ip, r_sid, r_rtr, r_mask;
`ifdef DHCP_LEASE_EN
    logic [31:0] r_sh_lease, r_lease;
`endif

    logic       w_take, w_err_set, w_hdr_bad, w_len_bad, w_at_max, w_enter_done, w_acc;
    logic [2:0] w_mac_idx;
    logic [7:0] w_xid_byte, w_mac_byte, w_magic_byte;

    assign s_axis_tready = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_take        = s_axis_tvalid && s_axis_tready;
    assign w_at_max      = (r_cnt == 11'(MAX_BYTES - 1));
    assign w_mac_idx     = 3'(r_cnt - 11'd28);
    assign w_xid_byte    = 8'(r_xid >> (8 * (3 - r_cnt[1:0])));
    assign w_mac_byte    = 8'(r_mac >> (8 * (5 - w_mac_idx)));
    assign w_magic_byte  = 8'(MAGIC >> (8 * (3 - r_cnt[1:0])));

    always_comb begin
        w_hdr_bad = 1'b0;
        if (r_cnt == 11'd0)                        w_hdr_bad = (s_axis_tdata != 8'h02);
        else if (r_cnt == 11'd1)                   w_hdr_bad = (s_axis_tdata != 8'h01);
        else if (r_cnt == 11'd2)                   w_hdr_bad = (s_axis_tdata != 8'h06);
        else if (r_cnt >= 11'd4 && r_cnt <= 11'd7)     w_hdr_bad = (s_axis_tdata != w_xid_byte);
        else if (r_cnt >= 11'd28 && r_cnt <= 11'd33)   w_hdr_bad = (s_axis_tdata != w_mac_byte);
        else if (r_cnt >= 11'd236 && r_cnt <= 11'd239) w_hdr_bad = (s_axis_tdata != w_magic_byte);
    end

    // Length sanity for the options we capture; the router list may carry extra addresses.
    always_comb begin
        w_len_bad = 1'b0;
        case (r_code)
            8'd1, 8'd54: w_len_bad = (s_axis_tdata != 8'd4);
            8'd3:        w_len_bad = (s_axis_tdata < 8'd4);
`ifdef DHCP_LEASE_EN
            8'd51:       w_len_bad = (s_axis_tdata != 8'd4);
`endif
            default:     w_len_bad = 1'b0;
        endcase
    end

    // NOTE: every signal assigned in this block gets a default first, so no latches are inferred.
    always_comb begin
        w_state_next = r_state;
        w_err_set    = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_state_next = S_HDR;
            S_HDR: if (w_take) begin
                w_err_set = w_hdr_bad;
                if (s_axis_tlast) begin
                    w_state_next = S_DONE;
                    w_err_set    = 1'b1;
                end else if (r_cnt == 11'd239) begin
                    w_state_next = S_OPT_CODE;
                end
            end
            S_OPT_CODE: if (w_take) begin
                if (s_axis_tdata == 8'hFF)      w_state_next = s_axis_tlast ? S_DONE : S_DRAIN;
                else if (s_axis_tlast)          w_state_next = S_DONE;
                else if (s_axis_tdata != 8'h00) w_state_next = S_OPT_LEN;
            end
            S_OPT_LEN: if (w_take) begin
                w_err_set = w_len_bad;
                if (s_axis_tlast) begin
                    w_state_next = S_DONE;
                    w_err_set    = 1'b1;
                end else begin
                    w_state_next = (s_axis_tdata == 8'd0) ? S_OPT_CODE : S_OPT_DATA;
                end
            end
            S_OPT_DATA: if (w_take) begin
                if (s_axis_tlast) begin
                    w_state_next = S_DONE;
                    w_err_set    = 1'b1;
                end else if (r_idx == r_len - 8'd1) begin
                    w_state_next = S_OPT_CODE;
                end
            end
            S_DRAIN: if (w_take && s_axis_tlast) w_state_next = S_DONE;
            S_DONE:  if (!start) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        // Oversized frame: give up parsing, mark it bad and swallow the rest.
        if (w_take && !s_axis_tlast && w_at_max && r_state != S_DRAIN) begin
            w_state_next = S_DRAIN;
            w_err_set    = 1'b1;
        end
    end

    assign w_enter_done = (w_state_next == S_DONE) && (r_state != S_DONE);
    assign w_acc = !(r_err || w_err_set) && r_seen53 && (r_sh_msg == 8'd2 || r_sh_msg == 8'd5);

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0; r_code <= '0; r_len <= '0; r_idx <= '0;
            r_err <= 1'b0; r_seen53 <= 1'b0; r_fin <= 1'b0; r_acc <= 1'b0;
            r_xid <= '0; r_mac <= '0;
            r_sh_msg <= '0; r_sh_ip <= '0; r_sh_sid <= '0; r_sh_rtr <= '0; r_sh_mask <= '0;
            r_msg <= '0; r_ip <= '0; r_sid <= '0; r_rtr <= '0; r_mask <= '0;
`ifdef DHCP_LEASE_EN
            r_sh_lease <= '0; r_lease <= '0;
`endif
        end else begin
            if (r_state == S_IDLE && start) begin
                r_xid    <= xid;
                r_mac    <= local_mac;
                r_cnt    <= '0;
                r_err    <= 1'b0;
                r_seen53 <= 1'b0;
            end
            if (w_take) begin
                if (r_cnt != 11'(MAX_BYTES)) r_cnt <= r_cnt + 11'd1;
                case (r_state)
                    S_HDR:
                        if (r_cnt >= 11'd16 && r_cnt <= 11'd19) r_sh_ip <= {r_sh_ip[23:0], s_axis_tdata};
                    S_OPT_CODE: r_code <= s_axis_tdata;
                    S_OPT_LEN: begin
                        r_len <= s_axis_tdata;
                        r_idx <= '0;
                    end
                    S_OPT_DATA: begin
                        r_idx <= r_idx + 8'd1;
                        if (r_idx < 8'd4) begin
                            case (r_code)
                                8'd1:  r_sh_mask <= {r_sh_mask[23:0], s_axis_tdata};
                                8'd3:  r_sh_rtr  <= {r_sh_rtr[23:0], s_axis_tdata};
                                8'd54: r_sh_sid  <= {r_sh_sid[23:0], s_axis_tdata};
`ifdef DHCP_LEASE_EN
                                8'd51: r_sh_lease <= {r_sh_lease[23:0], s_axis_tdata};
`endif
                                default: ;
                            endcase
                        end
                        if (r_code == 8'd53 && r_idx == 8'd0) begin
                            r_sh_msg <= s_axis_tdata;
                            r_seen53 <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            if (w_err_set) r_err <= 1'b1;
            if (w_enter_done) begin
                r_fin <= 1'b1;
                r_acc <= w_acc;
                if (w_acc) begin
                    r_msg <= r_sh_msg; r_ip <= r_sh_ip; r_sid <= r_sh_sid;
                    r_rtr <= r_sh_rtr; r_mask <= r_sh_mask;
`ifdef DHCP_LEASE_EN
                    r_lease <= r_sh_lease;
`endif
                end
            end else if (r_state == S_DONE && !start) begin
                r_fin <= 1'b0;
                r_acc <= 1'b0;
            end
        end
    end

    assign finished    = r_fin;
    assign accepted    = r_acc;
    assign msg_type    = r_msg;
    assign offered_ip  = r_ip;
    assign server_id   = r_sid;
    assign router_ip   = r_rtr;
    assign subnet_mask = r_mask;
`ifdef DHCP_LEASE_EN
    assign lease_time  = r_lease;
`endif
endmodule

// File: tb/tb_dhcp_reply_parser.sv
// Directed bench for dhcp_reply_parser: a table of whole frames with expected results,
// plus hand sequences for mid-frame reset and (with DHCP_LEASE_EN) lease capture.
module tb_dhcp_reply_parser;
    logic        clk = 1'b0;
    logic        rst, start, finished, accepted;
    logic [31:0] xid;
    logic [47:0] local_mac;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [7:0]  msg_type;
    logic [31:0] offered_ip, server_id, router_ip, subnet_mask;
`ifdef DHCP_LEASE_EN
    logic [31:0] lease_time;
`endif

    always #5 clk = ~clk;

    dhcp_reply_parser dut (
        .clk(clk), .rst(rst), .start(start), .finished(finished), .accepted(accepted),
        .xid(xid), .local_mac(local_mac),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .msg_type(msg_type), .offered_ip(offered_ip), .server_id(server_id),
        .router_ip(router_ip), .subnet_mask(subnet_mask)
`ifdef DHCP_LEASE_EN
        , .lease_time(lease_time)
`endif
    );

    typedef struct {
        int          kind;
        int          gap;
        logic        acc;
        logic [7:0]  msg;
        logic [31:0] ip, sid, rtr, mask;
    } vec_t;

    vec_t       vecs[9];
    logic [7:0] frame[$];
    int         n_pass = 0, n_total = 0;
    int         stalls;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    endtask

    task automatic push32(input logic [31:0] v);
        for (int k = 3; k >= 0; k--) frame.push_back(v[8*k +: 8]);
    endtask

    task automatic opt4(input logic [7:0] c, input logic [31:0] v);
        frame.push_back(c); frame.push_back(8'd4); push32(v);
    endtask

    task automatic opt1(input logic [7:0] c, input logic [7:0] v);
        frame.push_back(c); frame.push_back(8'd1); frame.push_back(v);
    endtask

    task automatic hdr(input logic [31:0] yi);
        frame.delete();
        for (int i = 0; i < 240; i++) frame.push_back(8'h00);
        frame[0] = 8'h02; frame[1] = 8'h01; frame[2] = 8'h06;
        for (int k = 0; k < 4; k++) begin
            frame[4 + k]   = xid[31 - 8*k -: 8];
            frame[16 + k]  = yi[31 - 8*k -: 8];
        end
        for (int k = 0; k < 6; k++) frame[28 + k] = local_mac[47 - 8*k -: 8];
        frame[236] = 8'h63; frame[237] = 8'h82; frame[238] = 8'h53; frame[239] = 8'h63;
    endtask

    task automatic build(input int kind);
        case (kind)
            0, 1, 3, 4, 7: begin
                hdr(kind == 7 ? 32'hC0A80299 : 32'hC0A80232);
                opt1(8'd53, kind == 4 ? 8'd5 : (kind == 7 ? 8'd3 : 8'd2));
                opt4(8'd54, 32'hC0A80201); opt4(8'd1, 32'hFFFFFF00); opt4(8'd3, 32'hC0A80201);
                frame.push_back(8'hFF);
                if (kind == 1) frame[7] = 8'h79;
                if (kind == 3) while (frame.size() > 101) void'(frame.pop_back());
            end
            2: begin
                hdr(32'hC0A80233);
                frame.push_back(8'h00); opt1(8'd53, 8'd2); frame.push_back(8'h00); frame.push_back(8'h00);
                opt4(8'd54, 32'hC0A80201); opt4(8'd1, 32'hFFFFFF00); frame.push_back(8'h00);
                frame.push_back(8'd3); frame.push_back(8'd8); push32(32'hC0A802FE); push32(32'hC0A80201);
                frame.push_back(8'hFF);
                for (int i = 0; i < 20; i++) frame.push_back(8'hAA);
            end
            5: begin
                hdr(32'hC0A80299);
                opt4(8'd54, 32'h0A000009); opt4(8'd1, 32'hFFFF0000); opt4(8'd3, 32'h0A000009);
                frame.push_back(8'hFF);
            end
            6: begin
                hdr(32'hC0A80299);
                opt1(8'd53, 8'd2);
                frame.push_back(8'd54); frame.push_back(8'd5); push32(32'h0A000009); frame.push_back(8'h00);
                opt4(8'd1, 32'hFFFF0000); frame.push_back(8'hFF);
            end
            8: begin
                hdr(32'hC0A80299);
                opt1(8'd53, 8'd2); opt4(8'd54, 32'h0A000009);
                while (frame.size() < 1099) frame.push_back(8'h00);
                frame.push_back(8'hFF);
            end
`ifdef DHCP_LEASE_EN
            9: begin
                hdr(32'hC0A80232);
                opt1(8'd53, 8'd5); opt4(8'd54, 32'hC0A80201); opt4(8'd51, 32'h00015180);
                frame.push_back(8'hFF);
            end
`endif
            default: frame.delete();
        endcase
    endtask

    // Streams `frame` with optional random idle cycles; stops early before index abort_at.
    task automatic send_frame(input int gap_pct, input int abort_at, output int n_stall);
        int i = 0;
        int cyc = 0;
        n_stall = 0;
        start = 1'b1;
        while (i < frame.size() && i != abort_at && cyc < 8000) begin
            @(negedge clk);
            cyc++;
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b0;
            end else begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = frame[i];
                s_axis_tlast  = (i == frame.size() - 1);
                if (s_axis_tready) i++;
                else if (i > 0) n_stall++;
            end
        end
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        if (cyc >= 8000) check("send_timeout", 32'(cyc), 32'd0);
    endtask

    task automatic wait_finished(input string name);
        int c = 0;
        while (!finished && c < 300) begin
            @(negedge clk);
            c++;
        end
        check(name, 32'(finished), 32'd1);
    endtask

    task automatic release_start();
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("fin_clear", 32'(finished), 32'd0);
        check("acc_clear", 32'(accepted), 32'd0);
    endtask

    initial begin
        vecs[0] = '{0, 0,  1'b1, 8'h02, 32'hC0A80232, 32'hC0A80201, 32'hC0A80201, 32'hFFFFFF00};
        vecs[1] = '{1, 0,  1'b0, 8'h02, 32'hC0A80232, 32'hC0A80201, 32'hC0A80201, 32'hFFFFFF00};
        vecs[2] = '{2, 0,  1'b1, 8'h02, 32'hC0A80233, 32'hC0A80201, 32'hC0A802FE, 32'hFFFFFF00};
        vecs[3] = '{3, 0,  1'b0, 8'h02, 32'hC0A80233, 32'hC0A80201, 32'hC0A802FE, 32'hFFFFFF00};
        vecs[4] = '{4, 50, 1'b1, 8'h05, 32'hC0A80232, 32'hC0A80201, 32'hC0A80201, 32'hFFFFFF00};
        vecs[5] = '{5, 0,  1'b0, 8'h05, 32'hC0A80232, 32'hC0A80201, 32'hC0A80201, 32'hFFFFFF00};
        vecs[6] = '{6, 0,  1'b0, 8'h05, 32'hC0A80232, 32'hC0A80201, 32'hC0A80201, 32'hFFFFFF00};
        vecs[7] = '{7, 0,  1'b0, 8'h05, 32'hC0A80232, 32'hC0A80201, 32'hC0A80201, 32'hFFFFFF00};
        vecs[8] = '{8, 0,  1'b0, 8'h05, 32'hC0A80232, 32'hC0A80201, 32'hC0A80201, 32'hFFFFFF00};

        rst = 1'b1; start = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = 8'h00;
        xid = 32'h12345678; local_mac = 48'h020000000001;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_finished", 32'(finished), 32'd0);
        check("rst_accepted", 32'(accepted), 32'd0);
        check("rst_tready", 32'(s_axis_tready), 32'd0);
        check("rst_offered_ip", offered_ip, 32'd0);
        check("rst_msg_type", 32'(msg_type), 32'd0);

        for (int v = 0; v < 9; v++) begin
            build(vecs[v].kind);
            send_frame(vecs[v].gap, -1, stalls);
            wait_finished($sformatf("v%0d_finished", v));
            if (v == 0) begin
                repeat (3) @(negedge clk);
                check("hold_finished", 32'(finished), 32'd1);
            end
            check($sformatf("v%0d_tready_done", v), 32'(s_axis_tready), 32'd0);
            check($sformatf("v%0d_accepted", v), 32'(accepted), 32'(vecs[v].acc));
            check($sformatf("v%0d_msg_type", v), 32'(msg_type), 32'(vecs[v].msg));
            check($sformatf("v%0d_offered_ip", v), offered_ip, vecs[v].ip);
            check($sformatf("v%0d_server_id", v), server_id, vecs[v].sid);
            check($sformatf("v%0d_router_ip", v), router_ip, vecs[v].rtr);
            check($sformatf("v%0d_subnet_mask", v), subnet_mask, vecs[v].mask);
            if (vecs[v].kind == 2) check("trailing_stalls", 32'(stalls), 32'd0);
            release_start();
        end

        // Reset in the middle of the option area: nothing finishes, outputs return to zero.
        build(0);
        send_frame(0, 245, stalls);
        rst = 1'b1; start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_offered_ip", offered_ip, 32'd0);
        check("midrst_tready", 32'(s_axis_tready), 32'd0);
        repeat (10) @(negedge clk);
        check("midrst_finished", 32'(finished), 32'd0);
        build(0);
        send_frame(0, -1, stalls);
        wait_finished("post_rst_finished");
        check("post_rst_accepted", 32'(accepted), 32'd1);
        check("post_rst_offered_ip", offered_ip, 32'hC0A80232);
        check("post_rst_router_ip", router_ip, 32'hC0A80201);
        release_start();

`ifdef DHCP_LEASE_EN
        build(9);
        send_frame(0, -1, stalls);
        wait_finished("lease_finished");
        check("lease_accepted", 32'(accepted), 32'd1);
        check("lease_time", lease_time, 32'h00015180);
        release_start();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
